// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes,
// the access-size enum, the FSM state enum and decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Unsigned variants only make sense for loads, so a store with
    // funct3[2] set decodes as illegal.
    function automatic lsu_size_e decode_size(input logic we, input logic [2:0] funct3);
        lsu_size_e size;
        case (funct3)
            F3_B:    size = SIZE_BYTE;
            F3_H:    size = SIZE_HALF;
            F3_W:    size = SIZE_WORD;
            F3_BU:   size = we ? SIZE_BAD : SIZE_BYTE;
            F3_HU:   size = we ? SIZE_BAD : SIZE_HALF;
            default: size = SIZE_BAD;
        endcase
        return size;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lo);
        logic mis;
        case (size)
            SIZE_HALF: mis = lo[0];
            SIZE_WORD: mis = (lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: pulls the addressed byte/half out of a
// memory word with sign or zero extension, and builds the merged word
// for sub-word stores. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed little-endian lane and extend it to 32 bits.
    always_comb begin
        case (lane)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SIZE_BYTE: load_data = {{24{~is_unsigned & byte_val[7]}}, byte_val};
            SIZE_HALF: load_data = {{16{~is_unsigned & half_val[15]}}, half_val};
            default:   load_data = rdata;
        endcase
    end

    // Replace only the target lane of the old word with the store data.
    always_comb begin
        merged = rdata;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            SIZE_WORD: merged = wdata;
            default:   merged = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-wide memory. One op at a time:
// accept in IDLE, access memory in ACCESS (and WRITE for sub-word stores,
// which need a read-modify-write), then a single-cycle response in RESP.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       hold_q;
    logic              err_q;

    lsu_size_e         size_q;
    logic              bad_op;
    logic              rmw;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    // Decode the captured request: access size, legality and whether a
    // store has to go through the read-modify-write path.
    always_comb begin
        size_q = decode_size(we_q, funct3_q);
        bad_op = (size_q == SIZE_BAD) || is_misaligned(size_q, addr_q[1:0]);
        rmw    = we_q && (size_q != SIZE_WORD);
    end

    lsu_align u_align (
        .size        (size_q),
        .is_unsigned (funct3_q[2]),
        .lane        (addr_q[1:0]),
        .rdata       (mem_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Sequencer; hold_q carries the load result or the merged store word,
    // and is cleared whenever it must not show up on resp_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            hold_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bad_op) begin
                        err_q  <= 1'b1;
                        hold_q <= 32'd0;
                        state  <= RESP;
                    end else if (!we_q) begin
                        hold_q <= load_data;
                        state  <= RESP;
                    end else if (rmw) begin
                        hold_q <= merged;
                        state  <= WRITE;
                    end else begin
                        hold_q <= 32'd0;
                        state  <= RESP;
                    end
                end
                WRITE: begin
                    hold_q <= 32'd0;
                    state  <= RESP;
                end
                RESP: begin
                    hold_q <= 32'd0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state only, so an asynchronous reset drops
    // the memory strobes immediately without waiting for a clock edge.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        case (state)
            ACCESS: begin
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (!bad_op) begin
                    if (!we_q || rmw) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        mem_wdata = wdata_q;
                    end
                end
            end
            WRITE: begin
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_write = 1'b1;
                mem_wdata = hold_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = hold_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for the LSU: directed cases with hand-computed
// results, an asynchronous reset in the middle of a read-modify-write, and
// randomized traffic against a shift-and-mask reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word memory seen by the DUT, and the model's copy of what it should hold.
    logic [31:0] mem    [0:63];
    logic [31:0] refmem [0:63];

    assign mem_rdata = mem[mem_addr[7:2]];

    // Memory samples its write strobe on the rising edge.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    int vectors = 0;
    int miscompares = 0;
    bit opActive = 1'b0;
    bit checkEnable = 1'b0;

    int          obsLatency, obsReads, obsWrites, obsReadCycle, obsWriteCycle;
    logic [31:0] obsRdata, obsReadAddr, obsWriteAddr, obsWriteData;
    logic        obsErr;

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: what a single op must do, from the size/sign/lane
    // rules expressed as shifts and masks on a 64-bit scratch value.
    function automatic void refOp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word,
                                  output logic err, output logic [31:0] rdata,
                                  output logic [31:0] newWord, output int reads,
                                  output int writes, output int latency);
        int size;
        int off;
        int sh;
        logic [63:0] mask;
        logic [63:0] val;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            3'b100:  size = we ? 0 : 1;
            3'b101:  size = we ? 0 : 2;
            default: size = 0;
        endcase
        off = int'(addr[1:0]);
        rdata = 32'd0;
        newWord = word;
        reads = 0;
        writes = 0;
        latency = 2;
        err = (size == 0) ? 1'b1 : ((off % size) != 0);
        if (!err) begin
            sh = 8 * off;
            mask = (64'd1 << (8 * size)) - 64'd1;
            if (!we) begin
                reads = 1;
                val = ({32'd0, word} >> sh) & mask;
                if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
                rdata = val[31:0];
            end else begin
                writes = 1;
                if (size < 4) begin
                    reads = 1;
                    latency = 3;
                end
                val = ({32'd0, word} & ~(mask << sh)) | (({32'd0, wdata} & mask) << sh);
                newWord = val[31:0];
            end
        end
    endfunction

    // Present one op, then watch the strobes and the response cycle by cycle
    // while driving junk on the request port that must be ignored.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int waitCycles = 0;
        while (!req_ready && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: req_ready still 0 after 10 cycles, expected 1");
        end
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        obsLatency = 0; obsReads = 0; obsWrites = 0; obsReadCycle = 0; obsWriteCycle = 0;
        obsRdata = 32'd0; obsErr = 1'b0;
        obsReadAddr = 32'd0; obsWriteAddr = 32'd0; obsWriteData = 32'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            opActive = 1'b1;
            if (mem_read) begin
                obsReads++;
                obsReadAddr = mem_addr;
                obsReadCycle = cyc;
            end
            if (mem_write) begin
                obsWrites++;
                obsWriteAddr = mem_addr;
                obsWriteData = mem_wdata;
                obsWriteCycle = cyc;
            end
            if (resp_valid) begin
                obsLatency = cyc;
                obsRdata = resp_rdata;
                obsErr = resp_err;
                req_valid = 1'b0;
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr = $urandom;
            req_wdata = $urandom;
        end
        if (obsLatency == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL resp_timeout: no resp_valid within 8 cycles of accept");
        end
        @(negedge clk);
        opActive = 1'b0;
        req_valid = 1'b0;
    endtask

    // Compare what was observed for the op against the reference model and
    // update the model's memory.
    task automatic checkOutput(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        logic        err;
        logic [31:0] rdata, newWord, expAddr;
        int          reads, writes, latency, idx;
        idx = int'(addr[7:2]);
        refOp(we, f3, addr, wdata, refmem[idx], err, rdata, newWord, reads, writes, latency);
        refmem[idx] = newWord;
        expAddr = {addr[31:2], 2'b00};
        checkValue("latency", obsLatency, latency);
        checkValue("resp_err", {31'd0, obsErr}, {31'd0, err});
        checkValue("resp_rdata", obsRdata, rdata);
        checkValue("read_count", obsReads, reads);
        checkValue("write_count", obsWrites, writes);
        checkValue("read_cycle", obsReadCycle, (reads != 0) ? 1 : 0);
        checkValue("write_cycle", obsWriteCycle, (writes != 0) ? ((reads != 0) ? 2 : 1) : 0);
        checkValue("read_addr", obsReadAddr, (reads != 0) ? expAddr : 32'd0);
        checkValue("write_addr", obsWriteAddr, (writes != 0) ? expAddr : 32'd0);
        checkValue("write_data", obsWriteData, (writes != 0) ? newWord : 32'd0);
        checkValue("mem_word", mem[idx], refmem[idx]);
    endtask

    // Per-cycle rules that hold regardless of which op is in flight.
    always begin
        @(negedge clk);
        #2;
        if (checkEnable && rst_n) begin
            checkValue("cyc_rw_overlap", {31'd0, mem_read & mem_write}, 32'd0);
            checkValue("cyc_req_ready", {31'd0, req_ready}, {31'd0, ~opActive});
            checkValue("cyc_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
            if (!mem_write) checkValue("cyc_wdata_idle", mem_wdata, 32'd0);
            if (!opActive) checkValue("cyc_idle_quiet", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] raddr, rwdata;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            refmem[i] = mem[i];
        end
        mem[0]  = 32'h80FF_1234; refmem[0]  = mem[0];
        mem[1]  = 32'hBEEF_0000; refmem[1]  = mem[1];
        mem[4]  = 32'h1122_3344; refmem[4]  = mem[4];
        mem[12] = 32'h5566_7788; refmem[12] = mem[12];

        #1 rst_n = 1'b0;
        #2;
        checkValue("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkValue("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        checkValue("rst_rdata", resp_rdata, 32'd0);
        checkValue("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        checkValue("rst_mem_addr", mem_addr, 32'd0);
        checkValue("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkEnable = 1'b1;
        @(negedge clk);

        // LB from the top byte of a word with its sign bit set
        applyStimulus(1'b0, 3'b000, 32'h0000_0003, 32'd0);
        checkOutput(1'b0, 3'b000, 32'h0000_0003, 32'd0);
        checkValue("lb_rdata", obsRdata, 32'hFFFF_FF80);
        checkValue("lb_err", {31'd0, obsErr}, 32'd0);
        checkValue("lb_latency", obsLatency, 32'd2);

        // LHU from the upper half
        applyStimulus(1'b0, 3'b101, 32'h0000_0006, 32'd0);
        checkOutput(1'b0, 3'b101, 32'h0000_0006, 32'd0);
        checkValue("lhu_rdata", obsRdata, 32'h0000_BEEF);

        // SB into lane 1 via read-modify-write
        applyStimulus(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA);
        checkOutput(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00AA);
        checkValue("sb_write_data", obsWriteData, 32'h1122_AA44);
        checkValue("sb_write_addr", obsWriteAddr, 32'h0000_0010);
        checkValue("sb_counts", {obsReads[15:0], obsWrites[15:0]}, 32'h0001_0001);
        checkValue("sb_mem", mem[4], 32'h1122_AA44);

        // SW goes straight to memory without a read
        applyStimulus(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF);
        checkOutput(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF);
        checkValue("sw_counts", {obsReads[15:0], obsWrites[15:0]}, 32'h0000_0001);
        checkValue("sw_mem", mem[8], 32'hDEAD_BEEF);
        checkValue("sw_latency", obsLatency, 32'd2);

        // Misaligned LW and an illegal funct3
        applyStimulus(1'b0, 3'b010, 32'h0000_0002, 32'd0);
        checkOutput(1'b0, 3'b010, 32'h0000_0002, 32'd0);
        checkValue("lw_mis_err", {31'd0, obsErr}, 32'd1);
        checkValue("lw_mis_strobes", {obsReads[15:0], obsWrites[15:0]}, 32'd0);
        applyStimulus(1'b0, 3'b011, 32'h0000_0004, 32'd0);
        checkOutput(1'b0, 3'b011, 32'h0000_0004, 32'd0);
        checkValue("f3_011_err", {31'd0, obsErr}, 32'd1);
        checkValue("f3_011_rdata", obsRdata, 32'd0);

        // Reset while an SH is in its write cycle
        checkEnable = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b001;
        req_addr = 32'h0000_0032;
        req_wdata = 32'h0000_1234;
        @(negedge clk);
        req_valid = 1'b0;
        checkValue("sh_rst_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        checkValue("sh_rst_write_before", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkValue("sh_rst_write_drop", {31'd0, mem_write}, 32'd0);
        checkValue("sh_rst_ready", {31'd0, req_ready}, 32'd1);
        checkValue("sh_rst_mem_addr", mem_addr, 32'd0);
        checkValue("sh_rst_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        checkValue("sh_rst_mem", mem[12], 32'h5566_7788);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkValue("sh_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        checkEnable = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            rwe = 1'($urandom);
            rf3 = 3'($urandom);
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr[31:8] = 24'd0;
            if ($urandom_range(0, 2) == 0) raddr[1:0] = 2'b00;
            rwdata = $urandom;
            applyStimulus(rwe, rf3, raddr, rwdata);
            checkOutput(rwe, rf3, raddr, rwdata);
        end

        checkEnable = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of req_addr/mem_addr.
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  pipeline presents memory op.
REQ-005 SHALL have port req_ready  out  1  LSU accepts op this cycle.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  in  3  RV32I size/sign code.
REQ-008 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  out  32  extended load result.
REQ-012 SHALL have port resp_err  out  1  misaligned or illegal funct3.
REQ-013 SHALL have port mem_read  out  1  word-memory read enable.
REQ-014 SHALL have port mem_write  out  1  word-memory write enable, sampled by memory on clk.
REQ-015 SHALL have port mem_addr  out  ADDR_W  word-aligned address, bits [1:0]=0.
REQ-016 SHALL have port mem_wdata  out  32  full word to write.
REQ-017 SHALL have port mem_rdata  in  32  combinational read data, valid same cycle as mem_read.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL register we/funct3/addr/wdata on req_valid&&req_ready and go to ACCESS; else stay IDLE.
REQ-020 SHALL decode funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned (loads only); any other code, or 1xx on a store, is illegal.
REQ-021 SHALL flag misaligned when half with addr[0]=1 or word with addr[1:0]!=0.
REQ-022 SHALL, for an illegal or misaligned op in ACCESS, drive no mem_read/mem_write and go to RESP with resp_err=1, resp_rdata=0.
REQ-023 SHALL, for a load in ACCESS, assert mem_read, capture lane-extracted, sign- or zero-extended mem_rdata, go to RESP; latency accept-edge to resp_valid = 2 cycles.
REQ-024 SHALL use little-endian lanes: byte lane addr[1:0], half lane addr[1].
REQ-025 SHALL, for a word store in ACCESS, assert mem_write with mem_wdata=req_wdata, go to RESP.
REQ-026 SHALL, for a byte/half store, read-modify-write: ACCESS asserts mem_read and registers the merged word (target lane replaced, others kept); WRITE asserts mem_write with that word; then RESP.
REQ-027 SHALL pulse resp_valid exactly one cycle in RESP, resp_rdata=0 for stores, then return to IDLE.
REQ-028 SHALL never assert mem_read and mem_write in the same cycle; both 0 in IDLE and RESP.
REQ-029 SHALL drive mem_addr={addr[ADDR_W-1:2],2'b00} in ACCESS/WRITE, 0 otherwise; mem_wdata 0 when mem_write=0.
REQ-030 SHALL ignore req_valid outside IDLE; back-to-back ops accepted no sooner than the cycle after RESP.

Reset
REQ-031 SHALL on rst_n=0 immediately enter IDLE and force req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL abandon any in-flight op on reset; a reset asserted in WRITE SHALL drop mem_write before the next clk edge, producing no memory write and no response.

Structure
REQ-033 SHALL place funct3 encodings, size enum and FSM state enum in shared package lsu_pkg.
REQ-034 SHALL isolate lane extraction/extension and store merge in combinational sub-module lsu_align.

Verification
REQ-035 SHALL test LB at 0x0000_0003, memory word 0x80FF_1234 -> resp_rdata 0xFFFF_FF80, resp_err=0, resp_valid 2 cycles after accept.
REQ-036 SHALL test LHU at 0x0000_0006, word 0xBEEF_0000 -> resp_rdata 0x0000_BEEF.
REQ-037 SHALL test SB 0xAA at 0x0000_0011 over word 0x1122_3344 -> one read then one write of 0x1122_AA44 to mem_addr 0x10.
REQ-038 SHALL test SW 0xDEAD_BEEF at 0x0000_0020 -> single mem_write, no mem_read, resp_valid next cycle.
REQ-039 SHALL test LW at 0x0000_0002 and funct3=011 -> resp_err=1, resp_rdata=0, no memory strobes.
REQ-040 SHALL test rst_n low during WRITE of SH -> mem_write drops asynchronously, target word unchanged, req_ready=1.
